// File: rtl/sys_rst_seq.sv
// Reset sequencer: releases peripheral reset, then core reset, after PLL lock is stable.
// Optional watchdog reset path is built when SYS_RST_WDT_EN is defined.
module sys_rst_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int ASSERT_CYC      = 32,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int CORE_DLY        = 16,
  parameter int WDT_CYC         = 2**24
) (
  input  logic       clk_sys,
  input  logic       rst_sys_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  input  logic       wdt_kick,
  output logic       rst_periph_n,
  output logic       rst_core_n,
  output logic       sys_ready,
  output logic [1:0] rst_cause
);

  localparam int MAX_AL  = (ASSERT_CYC > LOCK_STABLE_CYC) ? ASSERT_CYC : LOCK_STABLE_CYC;
  localparam int CNT_MAX = (MAX_AL > CORE_DLY) ? MAX_AL : CORE_DLY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] ST_ASSERT     = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] ST_STABLE     = 3'd2;
  localparam logic [2:0] ST_REL_PERIPH = 3'd3;
  localparam logic [2:0] ST_RUN        = 3'd4;

  localparam logic [1:0] CAUSE_PIN  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             cause_d;
  logic                   wdt_expire;

  assign lock_s = sync_q[SYNC_STAGES-1];

`ifdef SYS_RST_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYC);
  logic [WDT_W-1:0] wdt_q;

  // A kick on the expiry cycle keeps the system running.
  assign wdt_expire = (state_q == ST_RUN) && !wdt_kick && (wdt_q == WDT_W'(WDT_CYC - 1));

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      wdt_q <= '0;
    end else if (state_q != ST_RUN || wdt_kick) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_q + WDT_W'(1);
    end
  end
`else
  localparam int WDT_CYC_UNUSED = WDT_CYC;
  logic wdt_kick_unused;
  assign wdt_kick_unused = wdt_kick;
  assign wdt_expire      = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = rst_cause;

    case (state_q)
      ST_ASSERT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ASSERT_CYC - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LOCK_STABLE_CYC - 1)) state_d = ST_REL_PERIPH;
      end
      ST_REL_PERIPH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CORE_DLY - 1)) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_ASSERT;
    endcase

    // Reset causes, highest priority first; software requests only count in RUN.
    if (!lock_s && (state_q == ST_STABLE || state_q == ST_REL_PERIPH || state_q == ST_RUN)) begin
      state_d = ST_ASSERT;
      cause_d = CAUSE_LOCK;
    end else if (wdt_expire) begin
      state_d = ST_ASSERT;
      cause_d = CAUSE_WDT;
    end else if (sw_rst_req && state_q == ST_RUN) begin
      state_d = ST_ASSERT;
      cause_d = CAUSE_SW;
    end

    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decode state_d so they change on the same edge as the state, glitch-free.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      sync_q       <= '0;
      state_q      <= ST_ASSERT;
      cnt_q        <= '0;
      rst_cause    <= CAUSE_PIN;
      rst_periph_n <= 1'b0;
      rst_core_n   <= 1'b0;
      sys_ready    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_cause    <= cause_d;
      rst_periph_n <= (state_d == ST_REL_PERIPH) || (state_d == ST_RUN);
      rst_core_n   <= (state_d == ST_RUN);
      sys_ready    <= (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_sys_rst_seq.sv
// Scoreboard bench for sys_rst_seq: expected output vectors are queued per clock edge.
module tb_sys_rst_seq;

  typedef struct {
    int         edge_no;
    string      tag;
    logic [4:0] exp;
  } exp_t;

  // {rst_periph_n, rst_core_n, sys_ready, rst_cause}
  localparam logic [4:0] V_RST_PIN  = 5'b000_00;
  localparam logic [4:0] V_RST_LOCK = 5'b000_01;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic       clk_sys    = 1'b0;
  logic       rst_sys_n  = 1'b0;
  logic       pll_locked = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       wdt_kick   = 1'b0;
  logic       rst_periph_n, rst_core_n, sys_ready;
  logic [1:0] rst_cause;
  logic [4:0] obs;

  sys_rst_seq #(
    .SYNC_STAGES(2), .ASSERT_CYC(4), .LOCK_STABLE_CYC(8), .CORE_DLY(3), .WDT_CYC(20)
  ) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req), .wdt_kick(wdt_kick), .rst_periph_n(rst_periph_n),
    .rst_core_n(rst_core_n), .sys_ready(sys_ready), .rst_cause(rst_cause)
  );

  assign obs = {rst_periph_n, rst_core_n, sys_ready, rst_cause};

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input int edge_no, input string tag, input logic [4:0] exp);
    exp_t e;
    int   i;
    e.edge_no = edge_no;
    e.tag     = tag;
    e.exp     = exp;
    i = 0;
    while (i < sb_q.size() && sb_q[i].edge_no <= edge_no) i++;
    sb_q.insert(i, e);
  endtask

  // Full release sequence counted from the edge that entered ASSERT.
  task automatic expect_seq(input int a, input string tag, input logic [1:0] cause);
    expect_at(a + 12, {tag, "_pre_periph"}, {3'b000, cause});
    expect_at(a + 13, {tag, "_periph_up"},  {3'b100, cause});
    expect_at(a + 15, {tag, "_pre_core"},   {3'b100, cause});
    expect_at(a + 16, {tag, "_run"},        {3'b111, cause});
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk_sys);
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    @(negedge clk_sys);
    sw_rst_req = 1'b0;
  endtask

  task automatic pulse_kick(input int k);
    wait_until(k - 1);
    wdt_kick = 1'b1;
    @(negedge clk_sys);
    wdt_kick = 1'b0;
  endtask

  always @(negedge clk_sys) begin
    while (sb_q.size() > 0 && sb_q[0].edge_no <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.edge_no < cyc) check({e.tag, "_late"}, cyc, e.edge_no);
      else check($sformatf("%s@%0d", e.tag, e.edge_no), obs, e.exp);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int base, t, a, r, kl;
    logic [1:0] c6;

    // Reset state with no clock edge yet.
    #1;
    check("por_state", obs, V_RST_PIN);
    repeat (3) @(negedge clk_sys);
    check("rst_held", obs, V_RST_PIN);

    // 1: release with lock already present.
    rst_sys_n = 1'b1;
    base = cyc;
    expect_at(base + 4, "s1_assert", V_RST_PIN);
    expect_seq(base, "s1", 2'b00);
    wait_until(base + 20);

    // 2: lock loss for 3 cycles in RUN.
    t = cyc;
    pll_locked = 1'b0;
    expect_at(t + 2, "s2_still_run", 5'b111_00);
    expect_at(t + 3, "s2_lock_loss", V_RST_LOCK);
    expect_seq(t + 3, "s2", 2'b01);
    wait_until(t + 3);
    pll_locked = 1'b1;
    wait_until(t + 22);

    // 3: software reset in RUN, then an ignored request during STABLE.
    t = cyc;
    a = t + 1;
    expect_at(a, "s3_sw_rst", 5'b000_10);
    expect_seq(a, "s3", 2'b10);
    expect_at(a + 20, "s3_sw_ignored", 5'b111_10);
    pulse_sw();
    wait_until(a + 7);
    pulse_sw();
    wait_until(a + 22);

    // 4: software request and lock loss seen on the same edge.
    t = cyc;
    pll_locked = 1'b0;
    expect_at(t + 2, "s4_still_run", 5'b111_10);
    expect_at(t + 3, "s4_prio", V_RST_LOCK);
    expect_seq(t + 3, "s4", 2'b01);
    wait_until(t + 2);
    sw_rst_req = 1'b1;
    @(negedge clk_sys);
    sw_rst_req = 1'b0;
    pll_locked = 1'b1;
    r = t + 19;

    // 5: watchdog serviced every 15 cycles, then a kick exactly at expiry.
    kl = r + 195;
    expect_at(r + 19,  "s5_kick_a", 5'b111_01);
    expect_at(r + 21,  "s5_kick_b", 5'b111_01);
    expect_at(r + 200, "s5_kick_c", 5'b111_01);
    expect_at(kl + 20, "s5_kick_at_expiry", 5'b111_01);
`ifdef SYS_RST_WDT_EN
    expect_at(kl + 39, "s5_pre_expire", 5'b111_01);
    expect_at(kl + 40, "s5_wdt_rst", 5'b000_11);
    a  = kl + 40;
    c6 = 2'b11;
`else
    expect_at(kl + 40, "s5_no_wdt", 5'b111_01);
    a  = kl + 41;
    c6 = 2'b10;
    expect_at(a, "s5_sw_rst", 5'b000_10);
`endif
    for (int k = r + 15; k <= kl; k += 15) pulse_kick(k);
    pulse_kick(kl + 20);
`ifndef SYS_RST_WDT_EN
    wait_until(kl + 40);
    pulse_sw();
`endif

    // 6: board reset pulsed while in REL_PERIPH.
    expect_at(a + 12, "s6_pre_periph", {3'b000, c6});
    expect_at(a + 13, "s6_periph_up",  {3'b100, c6});
    wait_until(a + 14);
    #2 rst_sys_n = 1'b0;
    #1 check("s6_async_rst", obs, V_RST_PIN);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    base = cyc;
    expect_seq(base, "s6", 2'b00);
    wait_until(base + 17);

    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk_sys);
    check("sb_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
